// File: rtl/barrel_pkg.sv
// Shared definitions for the dynamic barrel shifter.
// Optional feature macro: BARREL_ROTATE_EN (adds the circular-rotate mode).
package barrel_pkg;

  // Default datapath width; must be a power of two >= 2.
  localparam int DATA_W  = 32;
  localparam int SHIFT_W = $clog2(DATA_W);

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHIFT_W-1:0] shamt_t;

  // Direction encoding: left moves bits toward the MSB.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_stage.sv
// One conditional shift-by-2^K stage of the barrel shifter.
// With BARREL_ROTATE_EN defined, the vacated bits can be refilled with the
// bits shifted out (rotate); otherwise they are always zero.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int K      = 0
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic              en,
  input  logic              direction,
`ifdef BARREL_ROTATE_EN
  input  logic              rotate,
`endif
  output logic [DATA_W-1:0] data_out
);

  // Distance moved by this stage when enabled; always < DATA_W.
  localparam int S = 1 << K;

  logic [S-1:0] fill_l;
  logic [S-1:0] fill_r;

  // Fill bits for the vacated positions: zero, or the wrapped-around bits.
  always_comb begin
    fill_l = '0;
    fill_r = '0;
`ifdef BARREL_ROTATE_EN
    if (rotate) begin
      fill_l = data_in[DATA_W-1 -: S];
      fill_r = data_in[S-1:0];
    end
`endif
  end

  // Pass through, or move by S in the selected direction.
  always_comb begin
    data_out = data_in;
    if (en) begin
      if (direction == DIR_LEFT) begin
        data_out = {data_in[DATA_W-S-1:0], fill_l};
      end else begin
        data_out = {fill_r, data_in[DATA_W-1:S]};
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_dynamic.sv
// Registered logical barrel shifter: one operand per clock, result one clock
// later. Optional feature macro: BARREL_ROTATE_EN (adds the rotate input).
//
// Handshake: valid_in qualifies data_in/shift_amt/direction(/rotate) in the
// cycle it is high; there is no ready, every valid operand is accepted unless
// rst is high on the same edge. valid_out is high for exactly the one cycle
// after an accepted operand; data_out holds its value while valid_out is low.
module barrel_shifter_dynamic
  import barrel_pkg::*;
#(
  parameter  int DATA_W  = barrel_pkg::DATA_W,
  localparam int SHIFT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               direction,
`ifdef BARREL_ROTATE_EN
  input  logic               rotate,
`endif
  output logic [DATA_W-1:0]  data_out,
  output logic               valid_out
);

  // stage_d[k] is the operand after stages 0..k-1 have been applied.
  logic [DATA_W-1:0] stage_d [SHIFT_W+1];

  assign stage_d[0] = data_in;

  // log2(DATA_W) mux stages; stage k moves by 2^k when shift_amt[k] is set.
  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    barrel_stage #(
      .DATA_W (DATA_W),
      .K      (k)
    ) u_stage (
      .data_in   (stage_d[k]),
      .en        (shift_amt[k]),
      .direction (direction),
`ifdef BARREL_ROTATE_EN
      .rotate    (rotate),
`endif
      .data_out  (stage_d[k+1])
    );
  end

  // Output register: reset wins, capture on valid, otherwise hold data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= stage_d[SHIFT_W];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_dynamic.sv
// Self-checking bench for barrel_shifter_dynamic: directed literal cases,
// then randomized traffic compared every cycle against a behavioural model.
module tb_barrel_shifter_dynamic;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic [SW-1:0] shift_amt;
  logic          direction;
  logic          rotate;
  logic [W-1:0]  data_out;
  logic          valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hold;
  logic         exp_valid;
  logic         checking;

  barrel_shifter_dynamic dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .shift_amt (shift_amt),
    .direction (direction),
`ifdef BARREL_ROTATE_EN
    .rotate    (rotate),
`endif
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                         input logic dir, input logic rot);
    logic [W-1:0] r;
    if (dir == 1'b0) r = d << amt;
    else             r = d >> amt;
`ifdef BARREL_ROTATE_EN
    if (rot && amt != 0) begin
      if (dir == 1'b0) r = r | (d >> (W - amt));
      else             r = r | (d << (W - amt));
    end
`else
    if (rot) r = r; // rotate has no effect without the feature
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard producer: decide at each edge what the outputs must become.
  always @(posedge clk) begin
    if (rst) begin
      exp_valid = 1'b0;
      exp_hold  = '0;
      exp_q.delete();
    end else begin
      exp_valid = valid_in;
      if (valid_in) exp_q.push_back(model(data_in, int'(shift_amt), direction, rotate));
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd1, 32'd0);
        end else begin
          exp_hold = exp_q.pop_front();
        end
      end
      check("data_out", data_out, exp_hold);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input int amt, input logic dir, input logic rot);
    valid_in  = 1'b1;
    data_in   = d;
    shift_amt = amt[SW-1:0];
    direction = dir;
    rotate    = rot;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    data_in   = $urandom;
    shift_amt = SW'($urandom_range(0, W-1));
    direction = 1'($urandom_range(0, 1));
    rotate    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;
    checking  = 1'b0;
    exp_valid = 1'b0;
    exp_hold  = '0;
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    shift_amt = '0;
    direction = 1'b0;
    rotate    = 1'b0;
    @(posedge clk); #1;
    checking = 1'b1;
    check("reset_data", data_out, 32'h0);
    check("reset_valid", {31'b0, valid_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Literal pins on the model itself.
    v = model(32'hA5A5A5A5, 2, 1'b0, 1'b0); check("model_l2", v, 32'h96969694);
    v = model(32'hA5A5A5A5, 4, 1'b1, 1'b0); check("model_r4", v, 32'h0A5A5A5A);
    v = model(32'h00000001, 31, 1'b0, 1'b0); check("model_l31", v, 32'h80000000);

    // Directed literal cases.
    send(32'hA5A5A5A5, 0, 1'b0, 1'b0);
    check("pass_data", data_out, 32'hA5A5A5A5);
    check("pass_valid", {31'b0, valid_out}, 32'h1);
    idle();
    check("hold_data", data_out, 32'hA5A5A5A5);
    check("hold_valid", {31'b0, valid_out}, 32'h0);

    send(32'hA5A5A5A5, 2, 1'b0, 1'b0); check("left2", data_out, 32'h96969694);
    send(32'hA5A5A5A5, 2, 1'b1, 1'b0); check("right2", data_out, 32'h29696969);
    send(32'hA5A5A5A5, 4, 1'b1, 1'b0); check("right4", data_out, 32'h0A5A5A5A);
    send(32'h00000001, 31, 1'b0, 1'b0);
    check("b2b_l31", data_out, 32'h80000000);
    check("b2b_v1", {31'b0, valid_out}, 32'h1);
    send(32'h80000000, 31, 1'b1, 1'b0);
    check("b2b_r31", data_out, 32'h00000001);
    check("b2b_v2", {31'b0, valid_out}, 32'h1);

`ifdef BARREL_ROTATE_EN
    send(32'hA5A5A5A5, 4, 1'b1, 1'b1); check("rot_r4", data_out, 32'h5A5A5A5A);
    send(32'hA5A5A5A5, 2, 1'b0, 1'b1); check("rot_l2", data_out, 32'h96969696);
`endif

    // Reset while an operand is presented: operand dropped.
    rst = 1'b1;
    send(32'hFFFFFFFF, 1, 1'b0, 1'b0);
    check("rst_drop_data", data_out, 32'h0);
    check("rst_drop_valid", {31'b0, valid_out}, 32'h0);
    rst = 1'b0;
    send(32'h12345678, 8, 1'b0, 1'b0); check("after_rst", data_out, 32'h34567800);
    idle();

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0) begin
        send($urandom, $urandom_range(0, W-1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        idle();
      end
    end
    rst = 1'b0;
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
